// File: rtl/sram_readout_if.sv
// Byte stream from the readout controller to the host link transmitter.
// A byte moves on every clk edge where tx_valid && tx_ready; once raised, tx_valid and tx_data hold until that transfer.
interface sram_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sram_readout.sv
// Capture SRAM readout: arms the ADC writer, waits for buffer-full, then streams
// every sample (address 0 upward) as a zero-padded high byte followed by the low byte.
module sram_readout #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 10,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              carry,
    output logic              we_en,
    output logic [ADDR_W-1:0] addr_r,
    input  logic [DATA_W-1:0] rd_data,
    sram_readout_if.master    tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        LOAD    = 3'd2,
        SEND_HI = 3'd3,
        SEND_LO = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_en_d, busy_d, done_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [15:0]         sample_ext;
    logic [15:0]         rd_ext;
    logic                tx_fire;
    logic                last_addr;

    assign sample_ext  = 16'(sample_q);
    assign rd_ext      = 16'(rd_data);
    assign tx_fire     = tx_valid_q && tx.tx_ready;
    assign last_addr   = (addr_r == ADDR_W'(DEPTH - 1));
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign state_dbg   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_en      <= 1'b0;
            addr_r     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_en      <= we_en_d;
            addr_r     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            sample_q   <= sample_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_en_d    = we_en;
        addr_d     = addr_r;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        sample_d   = sample_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    we_en_d = 1'b1;
                end
            end
            ARM: begin
                if (carry) begin
                    state_d = LOAD;
                    we_en_d = 1'b0;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                // addr_r was registered last cycle, so the SRAM output has settled
                sample_d   = rd_data;
                state_d    = SEND_HI;
                tx_valid_d = 1'b1;
                tx_data_d  = rd_ext[15:8];
            end
            SEND_HI: begin
                if (tx_fire) begin
                    state_d   = SEND_LO;
                    tx_data_d = sample_ext[7:0];
                end
            end
            SEND_LO: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    if (last_addr) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d = LOAD;
                        addr_d  = addr_r + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: doc/sram_readout.md
# sram_readout

Readout controller for the 2048×10 capture SRAM. It arms the ADC capture and waits for the buffer-full `carry` flag from the SRAM. It then drives the SRAM read address and streams every stored sample, oldest address first, as two bytes over a valid/ready byte interface to the host link transmitter. It sits between the capture SRAM's read port and the UART/USB byte transmitter.

## Interface
- `ADDR_W`, 11, SRAM address width.
- `DATA_W`, 10, sample width; must be ≤ 16.
- `DEPTH`, 2048, samples read per capture; equals 2**ADDR_W.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  capture request; sampled only in IDLE.
- `carry`  in  1  SRAM buffer-full flag; high for the cycle after a write to address DEPTH-1.
- `we_en`  out  1  capture enable to the ADC write side; the writer may assert SRAM `we` only while this is high.
- `addr_r`  out  ADDR_W  SRAM read address.
- `rd_data`  in  DATA_W  SRAM read data; combinational from `addr_r`, valid in the same cycle.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last byte is accepted.

## Operation
- States: IDLE, ARM, LOAD, SEND_HI, SEND_LO. All outputs are registered.
- Reset values: state=IDLE; `we_en`, `tx_valid`, `busy`, `done` = 0; `addr_r` = 0; `tx_data` = 0; sample register = 0.
- IDLE:
  - `start`=1 → ARM, `we_en`←1.
  - `carry` is ignored.
- ARM:
  - `start` is ignored.
  - `carry`=1 → LOAD, `we_en`←0, `addr_r`←0.
- LOAD:
  - sample register ← `rd_data`, which is stable because `addr_r` was registered in the previous cycle.
  - → SEND_HI with `tx_valid`←1 and `tx_data`←{zero-pad, sample[DATA_W-1:8]}. For DATA_W=10 this is {6'b0, s[9:8]}.
- SEND_HI: on `tx_valid`&&`tx_ready` → SEND_LO with `tx_data`←sample[7:0] and `tx_valid` held at 1.
- SEND_LO: on `tx_valid`&&`tx_ready`:
  - `tx_valid`←0.
  - if `addr_r`==DEPTH-1: → IDLE, `done`←1, `addr_r`←0.
  - otherwise: `addr_r`←`addr_r`+1, → LOAD.
- Handshake rules:
  - a transfer occurs only on a cycle with `tx_valid`&&`tx_ready`.
  - while `tx_valid`=1 and `tx_ready`=0, `tx_data` and `addr_r` hold.
  - `tx_valid` never drops without a transfer, except on reset.
- `addr_r` never wraps. The DEPTH-1 check terminates the readout before any increment past the top address.
- `busy` = (state != IDLE), registered alongside the state.
- A `start` pulse arriving in any non-IDLE state is dropped, not queued.
- `carry` outside ARM is ignored. A spurious `carry` during readout has no effect.

## Timing
- `start` sampled high at edge n → `we_en`=1 and `busy`=1 after edge n.
- `carry` sampled high at edge k → `we_en`=0 and `addr_r`=0 after edge k. First `tx_valid`=1 after edge k+1.
- With `tx_ready` tied to 1, each sample takes 3 cycles (LOAD, SEND_HI, SEND_LO). A full readout is 3·DEPTH = 6144 cycles from LOAD of address 0 to the `done` pulse.
- `done` is high for exactly the one cycle after the final SEND_LO transfer. `busy` is 0 in that same cycle, and a new `start` in that cycle is accepted.
- When `rst_n` is asserted mid-operation, all outputs take their reset values immediately (asynchronously), including `tx_valid`→0. No partial byte is completed. Deassertion is synchronous to `clk`.

## Test plan
- Reset/idle: hold `rst_n`=0, then release with `start`=0 and `carry` toggling → `busy`=`we_en`=`tx_valid`=0 and `addr_r`=0 throughout.
- Full capture, `tx_ready`=1: preload mem[i]=i mod 1024, pulse `start`, assert `carry` 10 cycles later → `we_en` falls on the next cycle. Exactly 4096 bytes are emitted in order {0x00,0x00},{0x00,0x01},…. Address 1023 yields {0x03,0xFF}. `done` pulses once, 6144 cycles after the first LOAD.
- Backpressure: random `tx_ready` at 30% duty → same 4096-byte sequence. `tx_data` is stable whenever `tx_valid`=1 and `tx_ready`=0, and no byte is duplicated or lost.
- Ignored inputs: `start` pulses during ARM and readout, and `carry` during SEND_HI → no state change and no extra bytes. Only one `done` pulse.
- Reset mid-readout: assert `rst_n`=0 during SEND_LO at `addr_r`=500 → `tx_valid`=0 and `addr_r`=0 immediately. After release, a fresh `start`/`carry` sequence reads from address 0.
- Back-to-back: `start` in the `done` cycle → ARM is entered next cycle. A second readout completes identically.
